vec_mag_apb_master: RTL

APB initiator that turns single-beat register commands on a valid/ready request channel into compliant APB3 SETUP/ACCESS transfers, and returns read data and error status on a valid/ready response channel. It is the requester end of the APB port on `vec_mag_top`. It lets on-chip sequencers and firmware bridges program the CTRL, STATUS, COUNT and OVF registers without a bus-functional model. It also adds a bounded-wait timeout so that a hung responder cannot stall the requester.

---
 rtl/vec_mag_apb_pkg.sv | 25 ++
 rtl/vec_mag_apb_master.sv | 137 +++++++++++++
 2 files changed

// File: rtl/vec_mag_apb_pkg.sv
// -----------------------------------------------------------------------------
// vec_mag_apb_pkg
// Shared definitions for the vec_mag APB register port:
//   - apb_mst_state_e : state encoding of the APB initiator FSM
//   - register map    : CTRL, STATUS, COUNT and OVF byte addresses
//   - CTRL bit fields : soft-reset release and clock enable positions
// -----------------------------------------------------------------------------
package vec_mag_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_mst_state_e;

   localparam logic [11:0] ADDR_CTRL   = 12'h000;
   localparam logic [11:0] ADDR_STATUS = 12'h004;
   localparam logic [11:0] ADDR_COUNT  = 12'h008;
   localparam logic [11:0] ADDR_OVF    = 12'h00C;

   localparam int CTRL_SRST_REL_BIT = 0;
   localparam int CTRL_CLK_EN_BIT   = 1;

endpackage

// File: rtl/vec_mag_apb_master.sv
// -----------------------------------------------------------------------------
// vec_mag_apb_master
// APB3 initiator. Accepts single-beat register commands on a valid/ready
// command channel, runs one SETUP/ACCESS transfer per command and returns the
// result on a valid/ready response channel. A bounded wait counter aborts an
// ACCESS phase whose responder never raises pready.
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o : command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i               : command payload (wdata ignored for reads)
//   rsp_valid_o / rsp_ready_i : response handshake
//   rsp_rdata_o               : read data (0 for writes and aborted transfers)
//   rsp_err_o                 : pslverr seen or timeout
//   rsp_timeout_o             : transfer aborted by timeout
//   psel_o .. pslverr_i       : APB initiator port
// -----------------------------------------------------------------------------
module vec_mag_apb_master
   import vec_mag_apb_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_write_i,
   input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      rsp_timeout_o,
   output logic                      psel_o,
   output logic                      penable_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic                      pwrite_o,
   output logic [DATA_WIDTH-1:0]     pwdata_o,
   input  logic [DATA_WIDTH-1:0]     prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   apb_mst_state_e   state;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;

   // The counter holds the number of wait cycles already seen, so the abort
   // fires in the ACCESS cycle after the TIMEOUT_CYCLES-th wait state.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         wait_cnt      <= '0;
         cmd_ready_o   <= 1'b0;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_err_o     <= 1'b0;
         rsp_timeout_o <= 1'b0;
         psel_o        <= 1'b0;
         penable_o     <= 1'b0;
         paddr_o       <= '0;
         pwrite_o      <= 1'b0;
         pwdata_o      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid_i && cmd_ready_o) begin
                  paddr_o     <= cmd_addr_i;
                  pwrite_o    <= cmd_write_i;
                  pwdata_o    <= cmd_write_i ? cmd_wdata_i : '0;
                  psel_o      <= 1'b1;
                  penable_o   <= 1'b0;
                  cmd_ready_o <= 1'b0;
                  wait_cnt    <= '0;
                  state       <= ST_SETUP;
               end else begin
                  // Raises ready the first cycle after reset release.
                  cmd_ready_o <= 1'b1;
               end
            end

            ST_SETUP: begin
               penable_o <= 1'b1;
               state     <= ST_ACCESS;
            end

            ST_ACCESS: begin
               // pready wins over a timeout landing in the same cycle.
               if (pready_i) begin
                  rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
                  rsp_err_o     <= pslverr_i;
                  rsp_timeout_o <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  psel_o        <= 1'b0;
                  penable_o     <= 1'b0;
                  state         <= ST_RESP;
               end else if (timeout_hit) begin
                  rsp_rdata_o   <= '0;
                  rsp_err_o     <= 1'b1;
                  rsp_timeout_o <= 1'b1;
                  rsp_valid_o   <= 1'b1;
                  psel_o        <= 1'b0;
                  penable_o     <= 1'b0;
                  state         <= ST_RESP;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o   <= 1'b0;
                  rsp_rdata_o   <= '0;
                  rsp_err_o     <= 1'b0;
                  rsp_timeout_o <= 1'b0;
                  cmd_ready_o   <= 1'b1;
                  state         <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
